// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the button conditioner: channel indices,
// default channel count and the per-channel debounce state encoding.
package btn_conditioner_pkg;

  localparam int BTN_P1_DOWN     = 0;
  localparam int BTN_P1_UP       = 1;
  localparam int BTN_P2_UP       = 2;
  localparam int BTN_P2_DOWN     = 3;
  localparam int BTN_LAUNCH      = 4;
  localparam int NUM_BTN_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ARM_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_ARM_RELEASE = 2'd3
  } btn_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_conditioner_channel.sv
// btn_channel: one button's 2-flop synchronizer, debounce FSM and auto-repeat
// timer. Level, press, release and repeat are all registered outputs.
module btn_channel
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);

  logic       r_sync1;
  logic       r_sync2;
  btn_state_e r_state;
  btn_state_e w_state_nxt;
  logic [CW-1:0] r_db_cnt;
  logic [CW-1:0] w_db_cnt_nxt;
  logic [CW-1:0] r_rep_cnt;
  logic [CW-1:0] w_rep_cnt_nxt;
  logic [CW-1:0] w_rep_cnt_adv;
  logic       r_rep_first;
  logic       w_rep_first_nxt;
  logic       w_rep_first_adv;
  logic       w_rep_hit;
  logic       r_level;
  logic       r_press;
  logic       r_release;
  logic       r_repeat;
  logic       w_level_nxt;
  logic       w_press_nxt;
  logic       w_release_nxt;
  logic       w_repeat_nxt;

  // First repeat waits REPEAT_DELAY after the press, later ones REPEAT_PERIOD.
  assign w_rep_hit       = r_rep_first ? (r_rep_cnt == RD_LAST) : (r_rep_cnt == RP_LAST);
  assign w_rep_cnt_adv   = w_rep_hit ? CNT_ZERO : (r_rep_cnt + CNT_ONE);
  assign w_rep_first_adv = r_rep_first & ~w_rep_hit;

  // Two-flop synchronizer for the asynchronous pin level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_db_cnt_nxt    = r_db_cnt;
    w_rep_cnt_nxt   = r_rep_cnt;
    w_rep_first_nxt = r_rep_first;
    w_level_nxt     = r_level;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_repeat_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_db_cnt_nxt = CNT_ZERO;
        if (r_sync2) w_state_nxt = ST_ARM_PRESS;
        else         w_state_nxt = ST_IDLE;
      end
      ST_ARM_PRESS: begin
        if (!r_sync2) begin
          w_state_nxt  = ST_IDLE;
          w_db_cnt_nxt = CNT_ZERO;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt     = ST_HELD;
          w_db_cnt_nxt    = CNT_ZERO;
          w_level_nxt     = 1'b1;
          w_press_nxt     = 1'b1;
          w_repeat_nxt    = 1'b1;
          w_rep_cnt_nxt   = CNT_ZERO;
          w_rep_first_nxt = 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        w_db_cnt_nxt    = CNT_ZERO;
        w_rep_cnt_nxt   = w_rep_cnt_adv;
        w_rep_first_nxt = w_rep_first_adv;
        w_repeat_nxt    = w_rep_hit;
        if (!r_sync2) w_state_nxt = ST_ARM_RELEASE;
        else          w_state_nxt = ST_HELD;
      end
      ST_ARM_RELEASE: begin
        if (r_sync2) begin
          w_state_nxt     = ST_HELD;
          w_db_cnt_nxt    = CNT_ZERO;
          w_rep_cnt_nxt   = w_rep_cnt_adv;
          w_rep_first_nxt = w_rep_first_adv;
          w_repeat_nxt    = w_rep_hit;
        end else if (r_db_cnt == DB_LAST) begin
          // Release wins over a coincident repeat.
          w_state_nxt     = ST_IDLE;
          w_db_cnt_nxt    = CNT_ZERO;
          w_level_nxt     = 1'b0;
          w_release_nxt   = 1'b1;
          w_rep_cnt_nxt   = CNT_ZERO;
          w_rep_first_nxt = 1'b0;
        end else begin
          w_db_cnt_nxt    = r_db_cnt + CNT_ONE;
          w_rep_cnt_nxt   = w_rep_cnt_adv;
          w_rep_first_nxt = w_rep_first_adv;
          w_repeat_nxt    = w_rep_hit;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_db_cnt_nxt    = CNT_ZERO;
        w_rep_cnt_nxt   = CNT_ZERO;
        w_rep_first_nxt = 1'b0;
        w_level_nxt     = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_db_cnt    <= CNT_ZERO;
      r_rep_cnt   <= CNT_ZERO;
      r_rep_first <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_db_cnt    <= w_db_cnt_nxt;
      r_rep_cnt   <= w_rep_cnt_nxt;
      r_rep_first <= w_rep_first_nxt;
      r_level     <= w_level_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_repeat    <= w_repeat_nxt;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: NUM_BTN independent debounced button channels plus a
// combined any_press strobe.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic               any_press
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .i_raw    (btn_raw[g]),
      .o_level  (btn_level[g]),
      .o_press  (btn_press[g]),
      .o_release(btn_release[g]),
      .o_repeat (btn_repeat[g])
    );
  end

  // Press pulses are already registered, so the OR lands in the same cycle.
  assign any_press = |btn_press;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with short debounce/repeat timing:
// directed scenarios plus randomized pins checked against a behavioural model.
module tb_btn_conditioner;

  localparam int NB = 5;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic          any_press;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_repeat(btn_repeat),
    .any_press(any_press)
  );

  // Reference model: a level flips once the synchronized pin has differed from
  // it for D+1 consecutive samples; repeats fire at t=0, RD, RD+RP, ... after press.
  logic [NB-1:0] m_s1, m_s2, e_level, e_press, e_rel, e_rep;
  logic [NB-1:0] n_lvl, n_press, n_rel, n_rep;
  int m_run [NB];
  int m_t   [NB];
  int n_run [NB];
  int n_t   [NB];

  always_comb begin
    n_lvl   = e_level;
    n_press = '0;
    n_rel   = '0;
    n_rep   = '0;
    for (int i = 0; i < NB; i++) begin
      n_t[i]   = m_t[i];
      n_run[i] = (m_s2[i] != e_level[i]) ? m_run[i] + 1 : 0;
      if (n_run[i] == D + 1) begin
        n_run[i] = 0;
        n_lvl[i] = ~e_level[i];
        if (!e_level[i]) begin
          n_press[i] = 1'b1;
          n_rep[i]   = 1'b1;
          n_t[i]     = 0;
        end else begin
          n_rel[i] = 1'b1;
        end
      end else if (e_level[i]) begin
        n_t[i] = m_t[i] + 1;
        if (n_t[i] == RD || (n_t[i] > RD && (n_t[i] - RD) % RP == 0)) n_rep[i] = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_s1 <= '0; m_s2 <= '0; e_level <= '0; e_press <= '0; e_rel <= '0; e_rep <= '0;
      for (int i = 0; i < NB; i++) begin
        m_run[i] <= 0;
        m_t[i]   <= 0;
      end
    end else begin
      m_s1 <= btn_raw; m_s2 <= m_s1;
      e_level <= n_lvl; e_press <= n_press; e_rel <= n_rel; e_rep <= n_rep;
      for (int i = 0; i < NB; i++) begin
        m_run[i] <= n_run[i];
        m_t[i]   <= n_t[i];
      end
    end
  end

  task test_reset;
    reset = 1'b0;
    btn_raw = 5'b11111;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++;
      if ({btn_level, btn_press, btn_release, btn_repeat, any_press} !== 21'd0) begin
        errors++;
        $display("FAIL reset_state cyc %0d got %h exp 0", j,
                 {btn_level, btn_press, btn_release, btn_repeat, any_press});
      end
    end
    btn_raw = 5'b00000;
    reset = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task test_latency;
    btn_raw[4] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if ({btn_level[4], btn_press[4], btn_repeat[4], any_press, btn_release[4]} !==
          {j >= 6, j == 6, j == 6, j == 6, 1'b0}) begin
        errors++;
        $display("FAIL press_latency edge+%0d got lvl=%b prs=%b rep=%b any=%b rel=%b",
                 j, btn_level[4], btn_press[4], btn_repeat[4], any_press, btn_release[4]);
      end
    end
    // Release is accepted exactly when the first repeat would be due.
    btn_raw[4] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      checks++;
      if ({btn_level[4], btn_release[4], btn_repeat[4], btn_press[4]} !==
          {j < 6, j == 6, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL release_vs_repeat edge+%0d got lvl=%b rel=%b rep=%b prs=%b exp lvl=%b rel=%b rep=0",
                 j, btn_level[4], btn_release[4], btn_repeat[4], btn_press[4], j < 6, j == 6);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task test_glitch;
    logic [7:0] pat;
    pat = 8'b0111_0111;
    for (int j = 0; j < 16; j++) begin
      btn_raw[0] = (j < 8) ? pat[j] : 1'b0;
      @(negedge clk);
      checks++;
      if ({btn_level, btn_press, btn_release, btn_repeat, any_press} !== 21'd0) begin
        errors++;
        $display("FAIL glitch cyc %0d got %h exp 0", j,
                 {btn_level, btn_press, btn_release, btn_repeat, any_press});
      end
    end
  endtask

  task test_repeat;
    int  wait_cyc;
    bit  exp_rep;
    btn_raw[1] = 1'b1;
    wait_cyc = 0;
    while (btn_press[1] !== 1'b1 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    if (wait_cyc != 7 || btn_repeat[1] !== 1'b1) begin
      errors++;
      $display("FAIL repeat_press_seen after %0d negedges rep=%b exp 7 and 1", wait_cyc, btn_repeat[1]);
      btn_raw[1] = 1'b0;
      repeat (12) @(negedge clk);
      return;
    end
    for (int t = 1; t <= 48; t++) begin
      if (t == 41) btn_raw[1] = 1'b0;
      @(negedge clk);
      exp_rep = (t < 47) && ((t == RD) || (t > RD && (t - RD) % RP == 0));
      checks++;
      if ({btn_repeat[1], btn_release[1], btn_level[1], btn_press[1]} !==
          {exp_rep, t == 47, t < 47, 1'b0}) begin
        errors++;
        $display("FAIL auto_repeat t=%0d got rep=%b rel=%b lvl=%b prs=%b exp rep=%b rel=%b lvl=%b",
                 t, btn_repeat[1], btn_release[1], btn_level[1], btn_press[1], exp_rep, t == 47, t < 47);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task test_simultaneous;
    int any_cnt;
    any_cnt = 0;
    btn_raw[3:2] = 2'b11;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (any_press) any_cnt++;
      checks++;
      if ({btn_press[3:2], btn_level[3:2], any_press, btn_press[1:0], btn_press[4]} !==
          {(j == 6) ? 2'b11 : 2'b00, (j >= 6) ? 2'b11 : 2'b00, j == 6, 3'b000}) begin
        errors++;
        $display("FAIL simultaneous edge+%0d got prs=%b lvl=%b any=%b", j, btn_press, btn_level, any_press);
      end
    end
    checks++;
    if (any_cnt != 1) begin
      errors++;
      $display("FAIL any_press_count got %0d exp 1", any_cnt);
    end
    btn_raw[3:2] = 2'b00;
    repeat (10) @(negedge clk);
  endtask

  task test_reset_mid_hold;
    btn_raw[4] = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (btn_level[4] !== 1'b1) begin
      errors++;
      $display("FAIL hold_before_reset got lvl=%b exp 1", btn_level[4]);
    end
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({btn_level, btn_press, btn_release, btn_repeat, any_press} !== 21'd0) begin
        errors++;
        $display("FAIL reset_mid_hold cyc %0d got %h exp 0", j,
                 {btn_level, btn_press, btn_release, btn_repeat, any_press});
      end
    end
    reset = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if ({btn_press[4], btn_level[4], btn_release[4]} !== {j == 6, j >= 6, 1'b0}) begin
        errors++;
        $display("FAIL fresh_press edge+%0d got prs=%b lvl=%b rel=%b exp prs=%b lvl=%b rel=0",
                 j, btn_press[4], btn_level[4], btn_release[4], j == 6, j >= 6);
      end
    end
    btn_raw[4] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task test_random;
    int hold [NB];
    for (int i = 0; i < NB; i++) hold[i] = $urandom_range(1, 8);
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      checks++;
      if ({btn_level, btn_press, btn_release, btn_repeat, any_press} !==
          {e_level, e_press, e_rel, e_rep, |e_press}) begin
        errors++;
        $display("FAIL random cyc %0d got lvl=%b prs=%b rel=%b rep=%b any=%b exp lvl=%b prs=%b rel=%b rep=%b",
                 c, btn_level, btn_press, btn_release, btn_repeat, any_press,
                 e_level, e_press, e_rel, e_rep);
      end
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NB; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 8);
        end
      end
    end
    reset = 1'b1;
    btn_raw = '0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    btn_raw = '0;
    test_reset();
    test_latency();
    test_glitch();
    test_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
